branch_pc_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 37 +++
 rtl/pc_reg.sv | 60 ++++++
 rtl/branch_pc_sequencer.sv | 102 ++++++++++
 tb/tb_branch_pc_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit and the branch/PC sequencer:
// sequencer state encoding, PC next-value selector, widths and condition codes.
package cpu_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam logic [DATA_W_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    // Branch sequencer states; IDLE must stay at encoding zero so a cleared
    // state register is always a legal idle machine.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STROBE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    // Selects which next-value source the PC register takes this cycle.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_LOAD = 2'd1,
        PC_INC  = 2'd2,
        PC_ADD  = 2'd3
    } pc_sel_t;

    // Branch condition codes driven by the control unit to the condition flip-flop.
    localparam logic [1:0] CC_ZERO     = 2'd0;
    localparam logic [1:0] CC_NONZERO  = 2'd1;
    localparam logic [1:0] CC_POSITIVE = 2'd2;
    localparam logic [1:0] CC_NEGATIVE = 2'd3;

    // States in which a branch is in flight (busy asserted).
    function automatic logic is_busy_state(input seq_state_t s);
        return (s == ST_STROBE) || (s == ST_WAIT) || (s == ST_UPDATE);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low clear, next-value mux
// (hold / absolute load / increment / add offset) and a single write enable.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  pc_sel_t           i_sel,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic [DATA_W-1:0] i_offset,
    output logic [DATA_W-1:0] o_pc
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] w_pc_next;
    logic              w_pc_we;

    // Choose the next PC value; addition wraps modulo 2^DATA_W.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        w_pc_next = r_pc;
        w_pc_we   = 1'b0;
        unique case (i_sel)
            PC_LOAD: begin
                w_pc_next = i_load_val;
                w_pc_we   = 1'b1;
            end
            PC_INC: begin
                w_pc_next = r_pc + ONE;
                w_pc_we   = 1'b1;
            end
            PC_ADD: begin
                w_pc_next = r_pc + i_offset;
                w_pc_we   = 1'b1;
            end
            default: begin
                w_pc_next = r_pc;
                w_pc_we   = 1'b0;
            end
        endcase
    end

    // PC storage with asynchronous clear to the reset vector.
    always_ff @(posedge clock or negedge clear) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!clear) begin
            r_pc <= RESET_PC;
        end else if (w_pc_we) begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/branch_pc_sequencer.sv
// Branch/PC sequencer: holds the PC, services increment and absolute load
// from the control unit, and runs conditional branches through the
// condition flip-flop (strobe, settle, sample, update, done).
module branch_pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              br_start,
    input  logic [DATA_W-1:0] br_offset,
    output logic              con_en,
    input  logic              con_in,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [DATA_W-1:0] pc_load_val,
    output logic [DATA_W-1:0] pc_out,
    output logic              busy,
    output logic              br_done,
    output logic              br_taken
);

    seq_state_t        r_state;
    logic [DATA_W-1:0] r_offset;
    logic              r_br_done;
    logic              r_br_taken;

    logic              w_idle;
    logic              w_accept_load;
    logic              w_accept_br;
    logic              w_accept_inc;
    pc_sel_t           w_pc_sel;

    // Request arbitration: only IDLE listens, load beats branch beats increment.
    assign w_idle        = (r_state == ST_IDLE);
    assign w_accept_load = w_idle && pc_load;
    assign w_accept_br   = w_idle && !pc_load && br_start;
    assign w_accept_inc  = w_idle && !pc_load && !br_start && pc_inc;

    // PC source select; con_in only matters in UPDATE.
    always_comb begin
        w_pc_sel = PC_HOLD;
        if (w_accept_load) begin
            w_pc_sel = PC_LOAD;
        end else if (w_accept_inc) begin
            w_pc_sel = PC_INC;
        end else if ((r_state == ST_UPDATE) && con_in) begin
            w_pc_sel = PC_ADD;
        end
    end

    // Branch FSM with its registered offset, done pulse and taken result.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= ST_IDLE;
            r_offset   <= '0;
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_br_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept_br) begin
                        r_offset <= br_offset;
                        r_state  <= ST_STROBE;
                    end
                end
                ST_STROBE: r_state <= ST_WAIT;
                // One full cycle for the condition flip-flop to settle.
                ST_WAIT:   r_state <= ST_UPDATE;
                ST_UPDATE: begin
                    r_br_taken <= con_in;
                    r_br_done  <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    pc_reg #(
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock      (clock),
        .clear      (clear),
        .i_sel      (w_pc_sel),
        .i_load_val (pc_load_val),
        .i_offset   (r_offset),
        .o_pc       (pc_out)
    );

    // Strobe and busy decode straight from the state register.
    assign con_en   = (r_state == ST_STROBE);
    assign busy     = is_busy_state(r_state);
    assign br_done  = r_br_done;
    assign br_taken = r_br_taken;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed bench for branch_pc_sequencer. Branch expectations go into a
// scoreboard queue; a monitor pops and compares them whenever br_done fires,
// and separately checks the con_en pulse width and counts strobes.
module tb_branch_pc_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } exp_t;

    logic        clock;
    logic        clear;
    logic        br_start;
    logic [31:0] br_offset;
    logic        con_en;
    logic        con_in;
    logic        pc_inc;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic [31:0] pc_out;
    logic        busy;
    logic        br_done;
    logic        br_taken;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_con_en = 0;
    int   exp_con_en = 0;
    int   con_run = 0;
    logic prev_con = 1'b0;
    logic prev_done = 1'b0;
    exp_t sb_q[$];

    branch_pc_sequencer #(
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .br_start    (br_start),
        .br_offset   (br_offset),
        .con_en      (con_en),
        .con_in      (con_in),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc_out      (pc_out),
        .busy        (busy),
        .br_done     (br_done),
        .br_taken    (br_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard compare on br_done, strobe width and count.
    always @(negedge clock) begin
        exp_t e;
        if (clear) begin
            if (con_en) begin
                con_run++;
            end else if (con_run != 0) begin
                check("con_en_width", con_run, 1);
                con_run = 0;
            end
            if (con_en && !prev_con) n_con_en++;
            prev_con = con_en;
            if (br_done) begin
                check("br_done_width", {31'b0, prev_done}, 0);
                check("sb_has_entry", {31'b0, sb_q.size() > 0}, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_pc", pc_out, e.pc);
                    check("sb_taken", {31'b0, br_taken}, {31'b0, e.taken});
                    check("sb_busy_in_done", {31'b0, busy}, 0);
                end
            end
            prev_done = br_done;
        end else begin
            con_run   = 0;
            prev_con  = 1'b0;
            prev_done = 1'b0;
        end
    end

    task automatic do_inc(input logic [31:0] exp_pc);
        @(posedge clock); #1;
        pc_inc = 1'b1;
        @(posedge clock); #1;
        pc_inc = 1'b0;
        check("inc_pc", pc_out, exp_pc);
        check("inc_busy", {31'b0, busy}, 0);
        check("inc_br_done", {31'b0, br_done}, 0);
    endtask

    task automatic do_load(input logic [31:0] val);
        @(posedge clock); #1;
        pc_load = 1'b1;
        pc_load_val = val;
        @(posedge clock); #1;
        pc_load = 1'b0;
        check("load_pc", pc_out, val);
    endtask

    // Full branch with edge-accurate timing; noise pulses requests in
    // STROBE/WAIT and pc_inc in DONE, all of which must be ignored.
    task automatic do_branch(input logic [31:0] off, input logic cond,
                             input logic [31:0] exp_pc, input logic noise);
        logic [31:0] pc_before;
        @(posedge clock); #1;
        pc_before = pc_out;
        br_start  = 1'b1;
        br_offset = off;
        con_in    = ~cond;
        sb_q.push_back('{pc: exp_pc, taken: cond});
        exp_con_en++;
        @(posedge clock); #1;          // edge k: STROBE
        br_start  = 1'b0;
        br_offset = 32'hDEAD_BEEF;
        check("strobe_con_en", {31'b0, con_en}, 1);
        check("strobe_busy", {31'b0, busy}, 1);
        if (noise) begin
            br_start    = 1'b1;
            pc_inc      = 1'b1;
            pc_load     = 1'b1;
            pc_load_val = 32'h0000_0999;
        end
        @(posedge clock); #1;          // edge k+1: WAIT
        check("wait_con_en", {31'b0, con_en}, 0);
        check("wait_pc_hold", pc_out, pc_before);
        @(posedge clock); #1;          // edge k+2: UPDATE
        br_start = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        con_in   = cond;
        check("update_pc_hold", pc_out, pc_before);
        @(posedge clock); #1;          // edge k+3: DONE
        con_in = ~cond;
        if (noise) pc_inc = 1'b1;
        @(posedge clock); #1;          // edge k+4: IDLE
        pc_inc = 1'b0;
        check("idle_pc", pc_out, exp_pc);
        check("taken_hold", {31'b0, br_taken}, {31'b0, cond});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear       = 1'b0;
        br_start    = 1'b0;
        br_offset   = '0;
        con_in      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", pc_out, 32'h0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_con_en", {31'b0, con_en}, 0);
        check("rst_br_done", {31'b0, br_done}, 0);
        check("rst_br_taken", {31'b0, br_taken}, 0);
        #2 clear = 1'b1;

        // Increment
        do_inc(32'h1);
        do_inc(32'h2);
        do_inc(32'h3);

        // Taken branch
        do_load(32'h100);
        do_branch(32'h20, 1'b1, 32'h120, 1'b0);

        // Negative offset, not taken then taken
        do_load(32'h100);
        do_branch(32'hFFFF_FFF0, 1'b0, 32'h100, 1'b0);
        do_branch(32'hFFFF_FFF0, 1'b1, 32'hF0, 1'b0);

        // Wrap
        do_load(32'hFFFF_FFFF);
        do_branch(32'h2, 1'b1, 32'h1, 1'b0);

        // Priority: load beats branch and increment
        @(posedge clock); #1;
        pc_load     = 1'b1;
        pc_load_val = 32'h40;
        br_start    = 1'b1;
        br_offset   = 32'h4;
        pc_inc      = 1'b1;
        @(posedge clock); #1;
        pc_load  = 1'b0;
        br_start = 1'b0;
        pc_inc   = 1'b0;
        check("prio_pc", pc_out, 32'h40);
        check("prio_busy", {31'b0, busy}, 0);
        check("prio_con_en", {31'b0, con_en}, 0);
        repeat (3) @(posedge clock);
        #1;
        check("prio_no_strobe", n_con_en, exp_con_en);
        check("prio_pc_stable", pc_out, 32'h40);

        // Requests during STROBE/WAIT/DONE ignored
        do_branch(32'h8, 1'b1, 32'h48, 1'b1);

        // Clear during WAIT
        do_load(32'h200);
        @(posedge clock); #1;
        br_start  = 1'b1;
        br_offset = 32'h10;
        con_in    = 1'b1;
        exp_con_en++;
        @(posedge clock); #1;          // STROBE
        br_start = 1'b0;
        @(posedge clock); #1;          // WAIT
        clear = 1'b0;
        #1;
        check("abort_pc", pc_out, 32'h0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_con_en", {31'b0, con_en}, 0);
        check("abort_br_taken", {31'b0, br_taken}, 0);
        @(posedge clock); #1;
        clear  = 1'b1;
        con_in = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("abort_pc_after", pc_out, 32'h0);
        check("abort_idle", {31'b0, busy}, 0);

        // Branch after clear, then PC=0 with offset -1
        do_branch(32'h5, 1'b1, 32'h5, 1'b0);
        do_load(32'h0);
        do_branch(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", sb_q.size(), 0);
        check("con_en_count", n_con_en, exp_con_en);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
